// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//   Next-state sequencer for the control-signal decoder. It steps the
//   fetch/decode/execute sequence 0..8 from the IR type bits, the
//   condition-test result and memory-operation-complete. A bounded moc wait
//   produces a bus error, an unsupported IR type produces an illegal-op pulse,
//   and a counter tracks retired instructions. Control strobes are decoded
//   downstream from o_state; this block only owns the state.
//
//   Optional feature macro: CU_SINGLE_STEP_EN
//     defined   : DECODE (state 4) holds until i_step_req=1, then decodes the
//                 ir_type/cond_true present on that cycle.
//     undefined : i_step_req is unused; DECODE always advances in one cycle.
//
// Ports
//   clk            in   1        rising-edge clock
//   rst_n          in   1        asynchronous active-low reset
//   i_ir_type      in   3        IR[27:25], sampled in DECODE only
//   i_cond_true    in   1        condition tester result, sampled in DECODE only
//   i_moc          in   1        memory op complete, sampled in IR_LOAD only
//   i_step_req     in   1        single-step request (CU_SINGLE_STEP_EN only)
//   o_state        out  STATE_W  registered current state (0..8)
//   o_illegal_op   out  1        one-cycle pulse: unsupported ir_type decoded
//   o_bus_err      out  1        one-cycle pulse: moc timeout in IR_LOAD
//   o_instr_count  out  CNT_W    retired-instruction count, wraps
// -----------------------------------------------------------------------------
module control_sequencer #(
  parameter int STATE_W     = 7,
  parameter int MOC_TIMEOUT = 15,
  parameter int TO_W        = 4,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         i_ir_type,
  input  logic               i_cond_true,
  input  logic               i_moc,
  input  logic               i_step_req,
  output logic [STATE_W-1:0] o_state,
  output logic               o_illegal_op,
  output logic               o_bus_err,
  output logic [CNT_W-1:0]   o_instr_count
);

  typedef enum logic [STATE_W-1:0] {
    S_RESET     = STATE_W'(0),
    S_FETCH_MAR = STATE_W'(1),
    S_PC_INC    = STATE_W'(2),
    S_IR_LOAD   = STATE_W'(3),
    S_DECODE    = STATE_W'(4),
    S_EXEC0     = STATE_W'(5),
    S_EXEC1     = STATE_W'(6),
    S_EXEC2     = STATE_W'(7),
    S_EXEC3     = STATE_W'(8)
  } state_t;

  state_t           r_state;
  logic [TO_W-1:0]  r_wait_cnt;
  logic             r_illegal_op;
  logic             r_bus_err;
  logic [CNT_W-1:0] r_instr_count;

  // Wait counter has already absorbed MOC_TIMEOUT idle cycles, so this is
  // the last cycle on which moc can still rescue the read.
  logic w_timeout_hit;
  assign w_timeout_hit = (r_wait_cnt == TO_W'(MOC_TIMEOUT));

  // DECODE may proceed this cycle.
  logic w_decode_go;
`ifdef CU_SINGLE_STEP_EN
  assign w_decode_go = i_step_req;
`else
  logic w_unused_step;
  assign w_decode_go   = 1'b1;
  assign w_unused_step = i_step_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_RESET;
      r_wait_cnt    <= '0;
      r_illegal_op  <= 1'b0;
      r_bus_err     <= 1'b0;
      r_instr_count <= '0;
    end else begin
      // Pulses are high only in the cycle after the event that caused them.
      r_illegal_op <= 1'b0;
      r_bus_err    <= 1'b0;
      case (r_state)
        S_RESET:     r_state <= S_FETCH_MAR;
        S_FETCH_MAR: r_state <= S_PC_INC;
        S_PC_INC: begin
          r_state    <= S_IR_LOAD;
          r_wait_cnt <= '0;
        end
        S_IR_LOAD: begin
          if (i_moc) begin
            // moc on the timeout cycle still wins over the bus error
            r_state    <= S_DECODE;
            r_wait_cnt <= '0;
          end else if (w_timeout_hit) begin
            r_state    <= S_RESET;
            r_bus_err  <= 1'b1;
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + TO_W'(1);
          end
        end
        S_DECODE: begin
          if (w_decode_go) begin
            if (!i_cond_true) begin
              r_state <= S_FETCH_MAR;
            end else begin
              case (i_ir_type)
                3'b000:  r_state <= S_EXEC0;
                3'b001:  r_state <= S_EXEC1;
                3'b010:  r_state <= S_EXEC2;
                3'b011:  r_state <= S_EXEC3;
                default: begin
                  r_state      <= S_FETCH_MAR;
                  r_illegal_op <= 1'b1;
                end
              endcase
            end
          end
        end
        S_EXEC0, S_EXEC1, S_EXEC2, S_EXEC3: begin
          r_state       <= S_FETCH_MAR;
          r_instr_count <= r_instr_count + CNT_W'(1);
        end
        // Any corrupted encoding recovers through RESET silently.
        default: begin
          r_state    <= S_RESET;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  assign o_state       = r_state;
  assign o_illegal_op  = r_illegal_op;
  assign o_bus_err     = r_bus_err;
  assign o_instr_count = r_instr_count;

endmodule
